// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame layout and parity helper.
// Used by both the keyboard transmitter and the SoC-side PS/2 receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    PS2_IDLE,
    PS2_HIGH,
    PS2_LOW,
    PS2_GAP,
    PS2_INHIB
  } ps2_tx_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_START_BIT  = 0;
  localparam int PS2_PARITY_BIT = 9;
  localparam int PS2_STOP_BIT   = 10;

  // Bit that makes the total count of ones over data+parity odd.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: serialises accepted scancode bytes into
// 11-bit device-to-host frames, aborting and retransmitting when the host inhibits.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int FREQ_HZ     = 2_000_000,
  parameter int PS2_FREQ_HZ = 12_500,
  parameter int GAP_CYCLES  = 2 * (FREQ_HZ / (2 * PS2_FREQ_HZ))
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [7:0] code_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       force_parity_err_i,
  input  logic       inhibit_i,
  output logic       ps2_clk_o,
  output logic       ps2_data_o,
  output logic       sent_o,
  output logic       abort_o
);

  localparam int HALF    = FREQ_HZ / (2 * PS2_FREQ_HZ);
  localparam int CNT_MAX = (HALF > GAP_CYCLES) ? HALF : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HALF_MID = CW'(HALF / 2);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  // The IDLE cycle in front of an accept is itself a line-high cycle, so the
  // GAP state is one cycle shorter when it hands over to IDLE than to a retry.
  localparam logic [CW-1:0] GAP_END_IDLE = CW'(GAP_CYCLES - 2);
  localparam logic [CW-1:0] GAP_END_RETX = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT     = 4'(PS2_STOP_BIT);

  if (HALF < 4) begin : g_half_check
    $error("ps2_kbd_tx: FREQ_HZ/(2*PS2_FREQ_HZ) must be at least 4");
  end
  if (GAP_CYCLES < 2) begin : g_gap_check
    $error("ps2_kbd_tx: GAP_CYCLES must be at least 2");
  end

  ps2_tx_state_t             state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [3:0]                bit_q, bit_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic                      data_q, data_d;
  logic                      retx_q, retx_d;
  logic                      sent_q, sent_d;
  logic                      abort_q, abort_d;
  logic                      accept;
  logic                      abort_now;
  logic                      gap_done;

  assign ready_o    = (state_q == PS2_IDLE) && !inhibit_i && !reset_i;
  assign accept     = valid_i && ready_o;
  assign ps2_clk_o  = (state_q != PS2_LOW);
  assign ps2_data_o = data_q;
  assign sent_o     = sent_q;
  assign abort_o    = abort_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    data_d    = data_q;
    retx_d    = retx_q;
    sent_d    = 1'b0;
    abort_d   = 1'b0;
    abort_now = inhibit_i && (bit_q != LAST_BIT);
    gap_done  = retx_q ? (cnt_q == GAP_END_RETX) : (cnt_q == GAP_END_IDLE);

    unique case (state_q)
      PS2_IDLE: begin
        data_d = 1'b1;
        if (accept) begin
          frame_d[PS2_START_BIT]  = 1'b0;
          frame_d[8:1]            = code_i;
          frame_d[PS2_PARITY_BIT] = ps2_odd_parity(code_i) ^ force_parity_err_i;
          frame_d[PS2_STOP_BIT]   = 1'b1;
          state_d = PS2_HIGH;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end

      PS2_HIGH: begin
        if (abort_now) begin
          state_d = PS2_INHIB;
          cnt_d   = '0;
          data_d  = 1'b1;
          retx_d  = 1'b1;
          abort_d = 1'b1;
        end else begin
          // Data moves mid-way through the high phase, well clear of both clock edges.
          if (cnt_q == HALF_MID) data_d = frame_q[bit_q];
          if (cnt_q == HALF_END) begin
            state_d = PS2_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      PS2_LOW: begin
        if (abort_now) begin
          state_d = PS2_INHIB;
          cnt_d   = '0;
          data_d  = 1'b1;
          retx_d  = 1'b1;
          abort_d = 1'b1;
        end else if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = PS2_GAP;
            sent_d  = 1'b1;
          end else begin
            state_d = PS2_HIGH;
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PS2_GAP: begin
        data_d = 1'b1;
        if (gap_done) begin
          cnt_d = '0;
          if (retx_q) begin
            state_d = PS2_HIGH;
            bit_d   = '0;
            retx_d  = 1'b0;
          end else begin
            state_d = PS2_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PS2_INHIB: begin
        data_d = 1'b1;
        if (!inhibit_i) begin
          state_d = PS2_GAP;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = PS2_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        data_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset_i) begin
      state_q <= PS2_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= 1'b1;
      retx_q  <= 1'b0;
      sent_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      retx_q  <= retx_d;
      sent_q  <= sent_d;
      abort_q <= abort_d;
    end
  end

  // NOTE: the frame register is left out of reset on purpose: it is only read
  // in HIGH, which can only be reached through an accept that loads it.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  // The host samples data on the falling clock edge, so data may only move while clock is high.
  data_stable_a: assert property (@(posedge clk) disable iff (reset_i)
    $changed(ps2_data_o) |-> ps2_clk_o);

endmodule
